// File: rtl/nv_nvdla_pdp_core_unit1d_pipe_skid.sv
// Fully registered valid/ready pipe stage with a one-entry skid register.
// Upstream ready and downstream valid/data all come straight from flops.
module nv_nvdla_pdp_core_unit1d_pipe_skid #(
  parameter int unsigned WIDTH = 185
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             pipe_in_vld_d0,
  input  logic [WIDTH-1:0] pipe_in_pd_d0,
  output logic             pipe_in_rdy_d0,
  output logic             pipe_in_vld_d1,
  output logic [WIDTH-1:0] pipe_in_pd_d1,
  input  logic             pipe_in_rdy_d1
);

  // Encoding is {main_vld, skid_vld}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic             main_vld, skid_vld;
  logic             rdy_q;
  logic [WIDTH-1:0] main_pd, skid_pd;
  logic             accept, send;
  logic             main_en, main_from_skid, skid_en;

  assign main_vld = state[1];
  assign skid_vld = state[0];
  assign accept   = pipe_in_vld_d0 && rdy_q;
  assign send     = main_vld && pipe_in_rdy_d1;

  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && send) begin
          main_en = 1'b1;
        end else if (accept) begin
          skid_en   = 1'b1;
          state_nxt = FULL;
        end else if (send) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (send) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Ready is its own flop so the upstream ready path carries no logic.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (main_en) begin
      main_pd <= main_from_skid ? skid_pd : pipe_in_pd_d0;
    end
    if (skid_en) begin
      skid_pd <= pipe_in_pd_d0;
    end
  end

  assign pipe_in_rdy_d0 = rdy_q;
  assign pipe_in_vld_d1 = main_vld;
  assign pipe_in_pd_d1  = main_pd;

endmodule

// File: tb/tb_nv_nvdla_pdp_core_unit1d_pipe_skid.sv
// Bench for the PDP unit1d skid stage: a 2-deep FIFO reference model checked
// every cycle, plus directed literal expectations for the key scenarios.
module tb_nv_nvdla_pdp_core_unit1d_pipe_skid;

  localparam int unsigned W = 185;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         vld_d0 = 1'b0;
  logic [W-1:0] pd_d0 = '0;
  logic         rdy_d1 = 1'b0;
  logic         rdy_d0, vld_d1;
  logic [W-1:0] pd_d1;
  logic         rdy_d0_8, vld_d1_8;
  logic [7:0]   pd_d1_8;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  nv_nvdla_pdp_core_unit1d_pipe_skid dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .pipe_in_vld_d0  (vld_d0),
    .pipe_in_pd_d0   (pd_d0),
    .pipe_in_rdy_d0  (rdy_d0),
    .pipe_in_vld_d1  (vld_d1),
    .pipe_in_pd_d1   (pd_d1),
    .pipe_in_rdy_d1  (rdy_d1)
  );

  nv_nvdla_pdp_core_unit1d_pipe_skid #(.WIDTH(8)) dut8 (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .pipe_in_vld_d0  (vld_d0),
    .pipe_in_pd_d0   (pd_d0[7:0]),
    .pipe_in_rdy_d0  (rdy_d0_8),
    .pipe_in_vld_d1  (vld_d1_8),
    .pipe_in_pd_d1   (pd_d1_8),
    .pipe_in_rdy_d1  (rdy_d1)
  );

  // Reference: the stage is a FIFO of capacity 2 whose ready reflects
  // the occupancy after the previous edge.
  logic [W-1:0] mq[$];
  bit           m_rdy = 1'b1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      bit acc, snd;
      acc = vld_d0 && m_rdy;
      snd = (mq.size() > 0) && rdy_d1;
      if (snd) void'(mq.pop_front());
      if (acc) mq.push_back(pd_d0);
      m_rdy = (mq.size() < 2);
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    chk("model_vld", W'(vld_d1), W'(mq.size() > 0));
    chk("model_rdy", W'(rdy_d0), W'(m_rdy));
    chk("w8_vld", W'(vld_d1_8), W'(mq.size() > 0));
    chk("w8_rdy", W'(rdy_d0_8), W'(m_rdy));
    if (mq.size() > 0) begin
      chk("model_pd", pd_d1, mq[0]);
      chk("w8_pd", W'(pd_d1_8), W'(mq[0][7:0]));
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    vld_d0 = v;
    pd_d0  = d;
    rdy_d1 = r;
    @(posedge clk);
    #1;
  endtask

  int unsigned idx;

  task automatic feed(input logic [W-1:0] base, input logic r);
    logic acc;
    acc = rdy_d0;
    step(1'b1, base + W'(idx), r);
    if (acc) idx++;
  endtask

  task automatic skid_fill(input logic [W-1:0] base);
    idx = 0;
    for (int i = 0; i < 3; i++) feed(base, 1'b1);
    chk("fill_pd_a2", pd_d1, base + 2);
    for (int i = 0; i < 4; i++) begin
      feed(base, 1'b0);
      chk("stall_pd", pd_d1, base + 2);
      chk("stall_pd8", W'(pd_d1_8), W'(8'(base + 2)));
      chk("stall_rdy", W'(rdy_d0), W'(0));
      chk("stall_vld", W'(vld_d1), W'(1));
    end
    chk("accepted_one_more", W'(idx), W'(4));
    feed(base, 1'b1);
    chk("recover_pd_a3", pd_d1, base + 3);
    chk("recover_rdy", W'(rdy_d0), W'(1));
    feed(base, 1'b1);
    chk("recover_pd_a4", pd_d1, base + 4);
    feed(base, 1'b1);
    chk("recover_pd_a5", pd_d1, base + 5);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("fill_drained", W'(vld_d1), W'(0));
  endtask

  initial begin
    // Reset held with upstream valid asserted.
    vld_d0 = 1'b1;
    pd_d0  = W'(8'h77);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_vld", W'(vld_d1), W'(0));
      chk("rst_rdy", W'(rdy_d0), W'(1));
    end
    rstn = 1'b1;
    step(1'b1, W'(1), 1'b1);
    chk("first_pd1", pd_d1, W'(1));
    chk("first_vld", W'(vld_d1), W'(1));
    step(1'b1, W'(2), 1'b1);
    chk("first_pd2", pd_d1, W'(2));
    step(1'b1, W'(3), 1'b1);
    chk("first_pd3", pd_d1, W'(3));
    step(1'b0, '0, 1'b1);
    chk("first_empty", W'(vld_d1), W'(0));

    skid_fill(W'(8'hA0));
    skid_fill(W'(8'hF0));

    // Drain to empty.
    step(1'b1, W'(8'h55), 1'b0);
    chk("drain_pd", pd_d1, W'(8'h55));
    step(1'b0, '0, 1'b1);
    chk("drain_vld", W'(vld_d1), W'(0));
    chk("drain_rdy", W'(rdy_d0), W'(1));

    // Mid-operation reset while FULL.
    step(1'b1, W'(8'hB1), 1'b0);
    step(1'b1, W'(8'hB2), 1'b0);
    chk("full_pd_b1", pd_d1, W'(8'hB1));
    chk("full_rdy", W'(rdy_d0), W'(0));
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_vld", W'(vld_d1), W'(0));
    chk("async_rst_rdy", W'(rdy_d0), W'(1));
    #4 rstn = 1'b1;
    step(1'b1, W'(8'hC0), 1'b1);
    chk("post_rst_pd_c0", pd_d1, W'(8'hC0));
    step(1'b0, '0, 1'b1);
    chk("post_rst_empty", W'(vld_d1), W'(0));

    // Random stress against the reference model.
    for (int unsigned i = 0; i < 10000; i++) begin
      logic [W-1:0] d;
      d = '0;
      d[31:0]    = $urandom();
      d[W-1-:32] = $urandom();
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
